// File: rtl/ri_point_reader_if.sv
// Range-image BRAM read port and polar point output stream of the point reader.
// Signal names are given from the reader's side (o_ = driven by the reader).
interface ri_point_reader_if;
    logic        o_rdEnable;
    logic [18:0] o_rdAddress;
    logic [15:0] i_rdData;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_azimuth;
    logic [15:0] o_elevation;
    logic [15:0] o_range;

    modport master (
        output o_rdEnable, o_rdAddress, o_valid, o_azimuth, o_elevation, o_range,
        input  i_rdData, i_ready
    );

    modport slave (
        input  o_rdEnable, o_rdAddress, o_valid, o_azimuth, o_elevation, o_range,
        output i_rdData, i_ready
    );
endinterface

// File: rtl/ri_point_reader.sv
// Scans a stored range image and emits one polar point (azimuth, elevation, range)
// per non-empty pixel, using incremental Q8 angle accumulators instead of dividers.
module ri_point_reader #(
    parameter int RI_WIDTH   = 1024,
    parameter int RI_HEIGHT  = 64,
    parameter int AZ_STEP_Q8 = 9000,
    parameter int EL_STEP_Q8 = 12000,
    parameter int MAX_ANGLE  = 1500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [18:0]       o_pointCount,
    ri_point_reader_if.master bus
);
    localparam int XW = (RI_WIDTH  > 1) ? $clog2(RI_WIDTH)  : 1;
    localparam int YW = (RI_HEIGHT > 1) ? $clog2(RI_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST    = XW'(RI_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(RI_HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE     = XW'(32'd1);
    localparam logic [YW-1:0] Y_ONE     = YW'(32'd1);
    localparam logic [31:0]   AZ_STEP   = 32'(AZ_STEP_Q8);
    localparam logic [31:0]   EL_STEP   = 32'(EL_STEP_Q8);
    localparam logic [15:0]   AZ_OFFSET = 16'd18000;
    localparam logic [15:0]   EL_TOP    = 16'(MAX_ANGLE);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        CAPT = 3'd2,
        OUT  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [31:0]   r_az_acc;
    logic [31:0]   r_el_acc;
    logic [18:0]   r_addr;
    logic [18:0]   r_point_count;
    logic          r_busy;
    logic          r_done;
    logic          r_rd_enable;
    logic          r_valid;
    logic [15:0]   r_azimuth;
    logic [15:0]   r_elevation;
    logic [15:0]   r_range;

    logic          w_start;
    logic          w_capture;
    logic          w_accept;
    logic          w_advance;
    logic          w_last;
    logic [15:0]   w_azimuth;
    logic [15:0]   w_elevation;

    // Next-state decode plus the per-cycle actions that the register block applies.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_last       = (r_x == X_LAST) && (r_y == Y_LAST);
        // Round to nearest centi-degree, then truncate to 16-bit two's complement.
        w_azimuth    = 16'((r_az_acc + 32'd128) >> 5'd8) - AZ_OFFSET;
        w_elevation  = EL_TOP - 16'((r_el_acc + 32'd128) >> 5'd8);
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_start      = 1'b1;
                    w_state_next = REQ;
                end else begin
                    w_state_next = IDLE;
                end
            end
            REQ: begin
                w_state_next = CAPT;
            end
            CAPT: begin
                if (bus.i_rdData == 16'd0) begin
                    w_advance    = 1'b1;
                    w_state_next = w_last ? FIN : REQ;
                end else begin
                    w_capture    = 1'b1;
                    w_state_next = OUT;
                end
            end
            OUT: begin
                if (r_valid && bus.i_ready) begin
                    w_accept     = 1'b1;
                    w_advance    = 1'b1;
                    w_state_next = w_last ? FIN : REQ;
                end else begin
                    w_state_next = OUT;
                end
            end
            FIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, pixel counters, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_az_acc      <= 32'd0;
            r_el_acc      <= 32'd0;
            r_addr        <= 19'd0;
            r_point_count <= 19'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rd_enable   <= 1'b0;
            r_valid       <= 1'b0;
            r_azimuth     <= 16'd0;
            r_elevation   <= 16'd0;
            r_range       <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            // Strobes follow the state being entered so they line up with it.
            r_rd_enable <= (w_state_next == REQ);
            r_valid     <= (w_state_next == OUT);
            r_done      <= (w_state_next == FIN);
            r_busy      <= (w_state_next == REQ) || (w_state_next == CAPT) ||
                           (w_state_next == OUT);

            if (w_start) begin
                r_x           <= '0;
                r_y           <= '0;
                r_az_acc      <= 32'd0;
                r_el_acc      <= 32'd0;
                r_addr        <= 19'd0;
                r_point_count <= 19'd0;
            end else if (w_advance && !w_last) begin
                r_addr <= r_addr + 19'd1;
                if (r_x == X_LAST) begin
                    r_x      <= '0;
                    r_az_acc <= 32'd0;
                    r_y      <= r_y + Y_ONE;
                    r_el_acc <= r_el_acc + EL_STEP;
                end else begin
                    r_x      <= r_x + X_ONE;
                    r_az_acc <= r_az_acc + AZ_STEP;
                end
            end

            if (w_accept) begin
                r_point_count <= r_point_count + 19'd1;
            end

            if (w_capture) begin
                r_range     <= bus.i_rdData;
                r_azimuth   <= w_azimuth;
                r_elevation <= w_elevation;
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pointCount    = r_point_count;
    assign bus.o_rdEnable  = r_rd_enable;
    assign bus.o_rdAddress = r_addr;
    assign bus.o_valid     = r_valid;
    assign bus.o_azimuth   = r_azimuth;
    assign bus.o_elevation = r_elevation;
    assign bus.o_range     = r_range;
endmodule

// File: tb/tb_ri_point_reader.sv
// Self-checking bench for ri_point_reader on a reduced 64x8 image with a scoreboard
// of expected points; angle expectations come from the closed-form angle formulas.
module tb_ri_point_reader;
    localparam int W    = 64;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int AZS  = 144000;   // 36000/64*256
    localparam int ELS  = 96000;    // 3000/8*256
    localparam int MAXA = 1500;

    typedef struct packed {
        logic [15:0] az;
        logic [15:0] el;
        logic [15:0] rng;
    } pt_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [18:0] o_pointCount;

    ri_point_reader_if bus();

    ri_point_reader #(
        .RI_WIDTH  (W),
        .RI_HEIGHT (H),
        .AZ_STEP_Q8(AZS),
        .EL_STEP_Q8(ELS),
        .MAX_ANGLE (MAXA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pointCount(o_pointCount),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:NPIX-1];
    pt_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.o_rdEnable === 1'b1) bus.i_rdData <= mem[bus.o_rdAddress[8:0]];
    end

    // Scoreboard: every handshake pops the oldest expected point.
    always @(negedge clk) begin
        pt_t e;
        if (bus.o_rdEnable === 1'b1) rd_cnt = rd_cnt + 1;
        if (o_done === 1'b1) done_cnt = done_cnt + 1;
        if (reset === 1'b0 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            xfer_cnt = xfer_cnt + 1;
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL point_unexpected got az=%0d el=%0d rng=%0d, required none",
                         $signed(bus.o_azimuth), $signed(bus.o_elevation), bus.o_range);
            end else begin
                e = exp_q.pop_front();
                if ({bus.o_azimuth, bus.o_elevation, bus.o_range} !== e) begin
                    n_errors = n_errors + 1;
                    $display("FAIL point_value got az=%0d el=%0d rng=%0d, required az=%0d el=%0d rng=%0d",
                             $signed(bus.o_azimuth), $signed(bus.o_elevation), bus.o_range,
                             $signed(e.az), $signed(e.el), e.rng);
                end
            end
        end
    end

    function automatic pt_t model_pt(int addr, logic [15:0] rng);
        int x;
        int y;
        pt_t p;
        x = addr % W;
        y = addr / W;
        p.az  = 16'(((x * AZS + 128) >>> 8) - 18000);
        p.el  = 16'(MAXA - ((y * ELS + 128) >>> 8));
        p.rng = rng;
        return p;
    endfunction

    task automatic push_pt(int az, int el, int rng);
        pt_t p;
        p.az  = 16'(az);
        p.el  = 16'(el);
        p.rng = 16'(rng);
        exp_q.push_back(p);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = 16'd0;
    endtask

    task automatic clear_counters();
        rd_cnt = 0;
        done_cnt = 0;
        xfer_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [89:0] obs;
        reset = 1'b1; i_start = 1'b1; bus.i_ready = 1'b0;
        clear_counters();
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {o_busy, o_done, o_pointCount, bus.o_rdEnable, bus.o_rdAddress, bus.o_valid,
               bus.o_azimuth, bus.o_elevation, bus.o_range};
        n_checks++;
        if (obs !== 90'd0) begin
            n_errors++; $display("FAIL reset_outputs got %h, required 0", obs);
        end
        @(posedge clk); #1 reset = 1'b0; i_start = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_cnt !== 0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_no_read got rd=%0d busy=%b, required 0 0", rd_cnt, o_busy);
        end
    endtask

    task automatic test_all_zero();
        int c0, exp_addr, exp_cyc, addr_bad, n_rd, n_valid, n_done, done_cyc, post;
        bit seen;
        clear_mem(); clear_counters(); bus.i_ready = 1'b1;
        @(posedge clk); #1 i_start = 1'b1; c0 = cyc;
        @(posedge clk); #1 i_start = 1'b0;
        exp_addr = 0; exp_cyc = c0 + 1; addr_bad = 0; n_rd = 0; n_valid = 0;
        n_done = 0; done_cyc = -1; post = 0; seen = 1'b0;
        for (int n = 0; n < 2 * NPIX + 50; n++) begin
            @(negedge clk);
            if (bus.o_rdEnable === 1'b1) begin
                if (bus.o_rdAddress !== 19'(exp_addr) || cyc != exp_cyc) addr_bad++;
                exp_addr++; exp_cyc += 2; n_rd++;
            end
            if (bus.o_valid !== 1'b0) n_valid++;
            if (o_done === 1'b1) begin
                n_done++;
                if (!seen) done_cyc = cyc;
                seen = 1'b1;
            end
            if (seen) begin
                post++;
                if (post > 4) break;
            end
        end
        n_checks++;
        if (addr_bad != 0 || n_rd != NPIX) begin
            n_errors++; $display("FAIL zero_addr_seq got bad=%0d reads=%0d, required 0 %0d", addr_bad, n_rd, NPIX);
        end
        n_checks++;
        if (n_valid != 0) begin
            n_errors++; $display("FAIL zero_no_valid got %0d, required 0", n_valid);
        end
        n_checks++;
        if (n_done != 1 || done_cyc != c0 + 2 * NPIX + 1) begin
            n_errors++; $display("FAIL zero_done got count=%0d at=%0d, required 1 at %0d",
                                 n_done, done_cyc - c0, 2 * NPIX + 1);
        end
        n_checks++;
        if (o_pointCount !== 19'd0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL zero_final got cnt=%0d busy=%b, required 0 0", o_pointCount, o_busy);
        end
    endtask

    task automatic test_single_point();
        bit seen;
        clear_mem(); clear_counters(); bus.i_ready = 1'b1;
        mem[32 + 4 * W] = 16'd1000;
        push_pt(0, 0, 1000);
        pulse_start();
        wait_done(2 * NPIX + 50, seen);
        n_checks++;
        if (!seen || done_cnt != 1 || o_pointCount !== 19'd1 || xfer_cnt != 1 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL single_point got done=%0d cnt=%0d xfers=%0d left=%0d, required 1 1 1 0",
                                 done_cnt, o_pointCount, xfer_cnt, exp_q.size());
        end
    endtask

    task automatic test_corners();
        bit seen;
        clear_mem(); clear_counters(); bus.i_ready = 1'b1;
        mem[0] = 16'd7;
        mem[NPIX - 1] = 16'd9;
        push_pt(-18000, 1500, 7);
        push_pt(17438, -1125, 9);
        pulse_start();
        wait_done(2 * NPIX + 50, seen);
        n_checks++;
        if (!seen || done_cnt != 1 || o_pointCount !== 19'd2 || xfer_cnt != 2 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL corners got done=%0d cnt=%0d xfers=%0d left=%0d, required 1 2 2 0",
                                 done_cnt, o_pointCount, xfer_cnt, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit seen, found;
        logic [47:0] snap;
        int unstable;
        clear_mem(); clear_counters(); bus.i_ready = 1'b0;
        mem[0] = 16'd7;
        push_pt(-18000, 1500, 7);
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++; $display("FAIL bp_valid_timeout got no o_valid, required o_valid within 20 cycles");
        end
        snap = {bus.o_azimuth, bus.o_elevation, bus.o_range};
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                @(posedge clk); #1 bus.i_ready = 1'b1;
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
            if (bus.o_valid !== 1'b1 || bus.o_rdEnable !== 1'b0 ||
                {bus.o_azimuth, bus.o_elevation, bus.o_range} !== snap) unstable++;
        end
        n_checks++;
        if (unstable != 0) begin
            n_errors++; $display("FAIL bp_stable got %0d unstable cycles, required 0", unstable);
        end
        wait_done(2 * NPIX + 50, seen);
        n_checks++;
        if (!seen || xfer_cnt != 1 || o_pointCount !== 19'd1 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL bp_count got xfers=%0d cnt=%0d left=%0d, required 1 1 0",
                                 xfer_cnt, o_pointCount, exp_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        int n_rd, post;
        bit seen, drop_start;
        clear_mem(); clear_counters(); bus.i_ready = 1'b1;
        mem[5] = 16'd100;
        mem[300] = 16'd200;
        exp_q.push_back(model_pt(5, 16'd100));
        exp_q.push_back(model_pt(300, 16'd200));
        pulse_start();
        n_rd = 0; post = 0; seen = 1'b0; drop_start = 1'b0;
        for (int n = 0; n < 2 * NPIX + 60; n++) begin
            @(negedge clk);
            if (drop_start) begin
                i_start = 1'b0;
                drop_start = 1'b0;
            end
            if (bus.o_rdEnable === 1'b1) begin
                n_rd++;
                if (n_rd == 100) begin
                    i_start = 1'b1;
                    drop_start = 1'b1;
                end
            end
            if (o_done === 1'b1) seen = 1'b1;
            if (seen) begin
                post++;
                if (post > 8) break;
            end
        end
        i_start = 1'b0;
        n_checks++;
        if (done_cnt != 1 || n_rd != NPIX || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL busy_start got done=%0d reads=%0d busy=%b, required 1 %0d 0",
                                 done_cnt, n_rd, o_busy, NPIX);
        end
        n_checks++;
        if (o_pointCount !== 19'd2 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL busy_points got cnt=%0d left=%0d, required 2 0", o_pointCount, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen, found;
        clear_mem(); clear_counters(); bus.i_ready = 1'b0;
        mem[10] = 16'd55;
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (!found || bus.o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL midreset_clear got found=%b valid=%b busy=%b, required 1 0 0",
                                 found, bus.o_valid, o_busy);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cnt != 0) begin
            n_errors++; $display("FAIL midreset_no_done got %0d, required 0", done_cnt);
        end
        bus.i_ready = 1'b1;
        exp_q.push_back(model_pt(10, 16'd55));
        pulse_start();
        @(negedge clk);
        n_checks++;
        if (bus.o_rdEnable !== 1'b1 || bus.o_rdAddress !== 19'd0) begin
            n_errors++; $display("FAIL midreset_restart got en=%b addr=%0d, required 1 0",
                                 bus.o_rdEnable, bus.o_rdAddress);
        end
        wait_done(2 * NPIX + 50, seen);
        n_checks++;
        if (!seen || done_cnt != 1 || o_pointCount !== 19'd1 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL midreset_rescan got done=%0d cnt=%0d left=%0d, required 1 1 0",
                                 done_cnt, o_pointCount, exp_q.size());
        end
    endtask

    task automatic test_random_points();
        int n_pts;
        bit seen;
        clear_mem(); clear_counters();
        for (int i = 0; i < 14; i++) mem[$urandom_range(0, NPIX - 1)] = 16'($urandom_range(1, 65535));
        n_pts = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (mem[a] != 16'd0) begin
                exp_q.push_back(model_pt(a, mem[a]));
                n_pts++;
            end
        end
        bus.i_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int n = 0; n < 4 * NPIX + 200; n++) begin
            @(posedge clk); #1 bus.i_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        bus.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (!seen || done_cnt != 1 || o_pointCount !== 19'(n_pts) || xfer_cnt != n_pts || exp_q.size() != 0) begin
            n_errors++; $display("FAIL random_points got done=%0d cnt=%0d xfers=%0d left=%0d, required 1 %0d %0d 0",
                                 done_cnt, o_pointCount, xfer_cnt, exp_q.size(), n_pts, n_pts);
        end
    endtask

    initial begin
        bus.i_ready = 1'b0;
        clear_mem();
        test_reset();
        test_all_zero();
        test_single_point();
        test_corners();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_scan();
        test_random_points();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ri_point_reader.md
Name: ri_point_reader

Overview:
- Inverse of the range-image write path: scans a stored range image and rebuilds one polar point per non-empty pixel.
- Pixel (x, y, range) becomes (azimuth, elevation, range).
- Sits between the range-image BRAM read port and downstream point consumers, e.g. a filter or a re-export DMA.
- Uses incremental fixed-point angle accumulators, so there are no dividers.

Parameters:
- RI_WIDTH, 1024: columns per image row.
- RI_HEIGHT, 64: rows per image.
- AZ_STEP_Q8, 9000: azimuth step per column, centi-degrees, Q8 (36000/1024*256).
- EL_STEP_Q8, 12000: elevation step per row, centi-degrees, Q8 (3000/64*256).
- MAX_ANGLE, 1500: elevation of row 0, centi-degrees.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- i_start  in  1  one-cycle request to scan the whole image.
- o_busy  out  1  high from start acceptance until o_done.
- o_done  out  1  one-cycle pulse when the scan completes.
- o_pointCount  out  19  number of points emitted in the last or current scan.
- o_rdEnable  out  1  memory read strobe.
- o_rdAddress  out  19  memory read address, y*RI_WIDTH + x.
- i_rdData  in  16  range word, valid exactly 1 cycle after o_rdEnable.
- o_valid  out  1  point valid.
- i_ready  in  1  downstream accepts the point.
- o_azimuth  out  16  signed centi-degrees, range -18000..+17999.
- o_elevation  out  16  signed centi-degrees.
- o_range  out  16  range word as stored.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE. All outputs become 0: o_busy, o_done, o_pointCount, o_rdEnable, o_rdAddress, o_valid, o_azimuth, o_elevation, o_range. Accumulators and x/y counters clear. Reset mid-scan abandons the scan: no o_done, and any pending point is dropped.
- States: IDLE, REQ, CAPT, OUT, FIN.
- IDLE:
  - i_start=1 → REQ, with o_busy=1, x=y=0, az_acc=el_acc=0, o_pointCount=0.
  - i_start in any other state is ignored.
- REQ: o_rdEnable=1 for this cycle only, o_rdAddress = y*RI_WIDTH + x. Next state CAPT.
- CAPT: sample i_rdData.
  - Value 0 (empty pixel): advance the pixel and go to REQ, or to FIN if this was the last pixel.
  - Nonzero value: register the outputs and go to OUT.
    - o_range = data.
    - o_azimuth = ((az_acc+128)>>8) - 18000.
    - o_elevation = MAX_ANGLE - ((el_acc+128)>>8).
- OUT:
  - o_valid=1. Outputs hold stable until i_ready=1.
  - On o_valid&&i_ready: o_valid drops next cycle, o_pointCount increments, the pixel advances, and the state goes to REQ, or FIN if this was the last pixel.
  - i_ready high before o_valid has no effect.
- Pixel advance:
  - x increments and az_acc += AZ_STEP_Q8.
  - At x = RI_WIDTH-1: x=0, az_acc=0, y increments, el_acc += EL_STEP_Q8.
  - The last pixel is x=RI_WIDTH-1, y=RI_HEIGHT-1. No wrap past it.
- FIN: o_done=1 for one cycle, o_busy=0, then IDLE. o_pointCount holds until the next accepted start.
- Timing:
  - Empty pixel costs 2 cycles.
  - Occupied pixel costs 3 cycles plus any stall cycles.
  - Start accepted in cycle N: first o_rdEnable in cycle N+1.
- Arithmetic:
  - az_acc and el_acc are 32-bit unsigned.
  - Angle results are 16-bit two's complement, truncated after rounding.
  - No saturation is needed for the default parameters.

Test Plan:
- Reset values: hold reset 3 cycles with i_start=1 → all outputs 0; no o_rdEnable while reset is high or after release without a new start.
- All-zero memory: pulse i_start → o_rdAddress steps through 0..65535, one address every 2 cycles; o_valid never asserts; o_done pulses exactly once, 131073 cycles after the start cycle; o_pointCount=0; o_busy then low.
- Single point, range 1000 at address 32*1024+512 (x=512, y=32): exactly one point, o_azimuth=0, o_elevation=0, o_range=1000; o_pointCount=1.
- Corner points:
  - Address 0, range 7 → az=-18000, el=+1500.
  - Address 65535, range 9 → az=+17965, el=-1453.
  - Emitted in address order; o_pointCount=2.
- Backpressure: the address-0 point with i_ready held low 5 cycles → o_valid and all three values stable for 6 cycles; no new o_rdEnable until the handshake; exactly one transfer counted.
- Start while busy, and reset mid-scan:
  - A second i_start at the 100th o_rdEnable is ignored: the scan finishes normally with a single o_done.
  - Reset asserted while o_valid=1 → next cycle o_valid=0 and o_busy=0; no o_done; a new i_start restarts at address 0.
